// File: rtl/register_file_multi_port_read.sv
// Frame/cell-state RAM with one write port and NUM_RD independent registered
// read ports. Each read port has an enable and a matching valid flag. A
// read-during-write policy and an optional second output register are
// selectable. A clear engine can sweep CLEAR_VALUE through every word.
//
// Handshake: rd_en_i[k] high at a rising edge is a read request on port k.
// rd_valid_o[k] is high for exactly one cycle, 1+OUT_REG edges later. During
// that cycle rd_data_o slice k carries the word. A cycle with no request drops
// valid low, and the data slice keeps its last value. There is no
// backpressure. Writes are fire-and-forget, and they are dropped while
// busy_o is high.
module register_file_multi_port_read #(
  parameter int                    DEPTH          = 307200,
  parameter int                    ADDR_WIDTH     = 19,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    NUM_RD         = 2,
  parameter int                    OUT_REG        = 0,
  parameter int                    BYPASS         = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter int                    CLEAR_ON_RESET = 0,
  parameter string                 ROM_FILE       = "zeros.mem"
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         wr_en_i,
  input  logic [ADDR_WIDTH-1:0]        wr_address_i,
  input  logic [DATA_WIDTH-1:0]        wr_data_i,
  input  logic [NUM_RD-1:0]            rd_en_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_address_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_valid_o,
  input  logic                         clear_i,
  output logic                         busy_o,
  output logic                         clear_done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam int                    IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

  // The storage array is never reset. An image named by ROM_FILE is bound to
  // it by the device configuration flow.
  (* ram_init_file = ROM_FILE *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_in_range;
  logic                  mem_we;

  // Clear-engine state register and sweep counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear-engine next state: a sweep runs from IDLE through DEPTH CLEAR cycles
  // into a single DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o       = (state_q == ST_CLEAR);
  assign clear_done_o = (state_q == ST_DONE);

  // Write-port arbitration: the clear engine owns the port while it is busy.
  always_comb begin
    wr_req  = wr_en_i;
    wr_addr = wr_address_i;
    wr_data = wr_data_i;
    if (busy_o) begin
      wr_req  = 1'b1;
      wr_addr = cnt_q;
      wr_data = CLEAR_VALUE;
    end
  end

  assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));
  assign mem_we      = wr_req & wr_in_range & ~reset_i;

  // RAM write. An out-of-range address never reaches the array.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] rd_addr;
      logic                  rd_in_range;
      logic                  rd_hit;
      logic [DATA_WIDTH-1:0] rd_word;
      logic [DATA_WIDTH-1:0] s1_data_q;
      logic                  s1_valid_q;

      assign rd_addr     = rd_address_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_in_range = (32'(rd_addr) < 32'(DEPTH));
      assign rd_hit      = (BYPASS != 0) && mem_we && (wr_addr == rd_addr);

      // Word seen by this port. An out-of-range address reads as zero. A
      // same-edge write to the same word is forwarded when bypass is selected.
      always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
          rd_word = rd_hit ? wr_data : mem[rd_addr[IDX_W-1:0]];
        end
      end

      // First read register: it captures the word on enable and holds it
      // otherwise.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          s1_data_q  <= '0;
          s1_valid_q <= 1'b0;
        end else begin
          s1_valid_q <= rd_en_i[k];
          if (rd_en_i[k]) begin
            s1_data_q <= rd_word;
          end
        end
      end

      if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_valid_q;

        // Optional output register: it delays data and valid by one more
        // cycle.
        always_ff @(posedge clk_i or posedge reset_i) begin
          if (reset_i) begin
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
          end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
              s2_data_q <= s1_data_q;
            end
          end
        end

        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = s2_data_q;
        assign rd_valid_o[k]                         = s2_valid_q;
      end else begin : g_no_out_reg
        assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = s1_data_q;
        assign rd_valid_o[k]                         = s1_valid_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_register_file_multi_port_read.sv
// Directed bench for register_file_multi_port_read.
// Instance A: OUT_REG=0, BYPASS=1, CLEAR_ON_RESET=0.
// Instance B: OUT_REG=1, BYPASS=0, CLEAR_ON_RESET=1.
// Both instances share every input and use DEPTH=16, ADDR_WIDTH=5, NUM_RD=3
// and CLEAR_VALUE=0x11.
module tb_register_file_multi_port_read;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NR = 3;

  logic               clk_i;
  logic               reset_i;
  logic               wr_en_i;
  logic [AW-1:0]      wr_address_i;
  logic [DW-1:0]      wr_data_i;
  logic [NR-1:0]      rd_en_i;
  logic [NR*AW-1:0]   rd_address_i;
  logic               clear_i;

  logic [NR*DW-1:0]   rd_data_a;
  logic [NR-1:0]      rd_valid_a;
  logic               busy_a;
  logic               done_a;
  logic [NR*DW-1:0]   rd_data_b;
  logic [NR-1:0]      rd_valid_b;
  logic               busy_b;
  logic               done_b;

  int n_cmp = 0;
  int n_err = 0;

  register_file_multi_port_read #(
    .DEPTH(16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .OUT_REG(0),
    .BYPASS(1), .CLEAR_VALUE(8'h11), .CLEAR_ON_RESET(0), .ROM_FILE("")
  ) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .wr_en_i(wr_en_i),
    .wr_address_i(wr_address_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_address_i(rd_address_i), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a),
    .clear_i(clear_i), .busy_o(busy_a), .clear_done_o(done_a)
  );

  register_file_multi_port_read #(
    .DEPTH(16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .OUT_REG(1),
    .BYPASS(0), .CLEAR_VALUE(8'h11), .CLEAR_ON_RESET(1), .ROM_FILE("")
  ) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .wr_en_i(wr_en_i),
    .wr_address_i(wr_address_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_address_i(rd_address_i), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b),
    .clear_i(clear_i), .busy_o(busy_b), .clear_done_o(done_b)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples busy/done over a sweep window. It optionally issues writes of
  // 0xEE to word 1 a few cycles into the window.
  task automatic watch(input bit do_wr, output int ab, output int ad,
                       output int bb, output int bd);
    ab = 0; ad = 0; bb = 0; bd = 0;
    for (int i = 0; i < 21; i++) begin
      if (busy_a) ab++;
      if (done_a) ad++;
      if (busy_b) bb++;
      if (done_b) bd++;
      wr_en_i      = do_wr && (i >= 3) && (i <= 7);
      wr_address_i = 5'd1;
      wr_data_i    = 8'hEE;
      tick();
    end
    wr_en_i = 1'b0;
  endtask

  // Reads one word on port 0. A is sampled after one edge and B after two.
  task automatic read_word(input logic [AW-1:0] addr, output logic [DW-1:0] va,
                           output logic [DW-1:0] vb);
    rd_address_i = {10'd0, addr};
    rd_en_i      = 3'b001;
    tick();
    va      = rd_data_a[7:0];
    rd_en_i = 3'b000;
    tick();
    vb = rd_data_b[7:0];
  endtask

  initial begin
    int ab, ad, bb, bd;
    logic [DW-1:0] va, vb;

    reset_i = 1'b0; wr_en_i = 1'b0; wr_address_i = '0; wr_data_i = '0;
    rd_en_i = '0; rd_address_i = '0; clear_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    // reset state
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    chk("rst_valid_a", 32'(rd_valid_a), 32'd0);
    chk("rst_data_a", 32'(rd_data_a), 32'd0);
    chk("rst_data_b", 32'(rd_data_b), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    tick(); tick();
    reset_i = 1'b0;

    // B sweeps automatically out of reset, and A stays idle.
    watch(1'b1, ab, ad, bb, bd);
    chk("por_busy_a", 32'(ab), 32'd0);
    chk("por_busy_b", 32'(bb), 32'd16);
    chk("por_done_b", 32'(bd), 32'd1);

    // clear_i pulse on both instances; the writes issued while busy are lost
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    watch(1'b1, ab, ad, bb, bd);
    chk("clr_busy_a", 32'(ab), 32'd16);
    chk("clr_done_a", 32'(ad), 32'd1);
    chk("clr_busy_b", 32'(bb), 32'd16);
    chk("clr_done_b", 32'(bd), 32'd1);

    // every word reads 0x11 on all three ports
    for (int a = 0; a < 16; a++) begin
      rd_address_i = {5'((a + 11) % 16), 5'((a + 5) % 16), 5'(a)};
      rd_en_i      = 3'b111;
      tick();
      chk($sformatf("clr_rd_a_%0d", a), 32'({rd_valid_a, rd_data_a}), 32'h7_111111);
      rd_en_i = 3'b000;
      tick();
      chk($sformatf("clr_rd_b_%0d", a), 32'({rd_valid_b, rd_data_b}), 32'h7_111111);
    end

    // test 1: write 0x5A@3, then read @3,3,7
    wr_en_i = 1'b1; wr_address_i = 5'd3; wr_data_i = 8'h5A;
    tick();
    wr_en_i = 1'b0;
    rd_address_i = {5'd7, 5'd3, 5'd3};
    rd_en_i      = 3'b111;
    tick();
    chk("t1_a_valid", 32'(rd_valid_a), 32'h7);
    chk("t1_a_data", 32'(rd_data_a), 32'h115A5A);
    chk("t1_b_early_valid", 32'(rd_valid_b), 32'h0);
    rd_en_i = 3'b000;
    tick();
    chk("t1_b_valid", 32'(rd_valid_b), 32'h7);
    chk("t1_b_data", 32'(rd_data_b), 32'h115A5A);
    chk("t1_a_valid_off", 32'(rd_valid_a), 32'h0);
    chk("t1_a_hold", 32'(rd_data_a), 32'h115A5A);

    // test 2: same-edge write 0xC3@5 and read @5
    wr_en_i = 1'b1; wr_address_i = 5'd5; wr_data_i = 8'hC3;
    rd_address_i = {5'd5, 5'd5, 5'd5};
    rd_en_i      = 3'b111;
    tick();
    wr_en_i = 1'b0; rd_en_i = 3'b000;
    chk("t2_a_bypass", 32'(rd_data_a), 32'hC3C3C3);
    tick();
    chk("t2_b_old", 32'(rd_data_b), 32'h111111);
    rd_en_i = 3'b111;
    tick();
    rd_en_i = 3'b000;
    chk("t2_a_reread", 32'(rd_data_a), 32'hC3C3C3);
    tick();
    chk("t2_b_reread", 32'(rd_data_b), 32'hC3C3C3);

    // test 5: out-of-range write and read at 20; word 4 is the alias
    wr_en_i = 1'b1; wr_address_i = 5'd20; wr_data_i = 8'h99;
    rd_address_i = {5'd20, 5'd4, 5'd20};
    rd_en_i      = 3'b111;
    tick();
    wr_en_i = 1'b0; rd_en_i = 3'b000;
    chk("t5_a", 32'({rd_valid_a, rd_data_a}), 32'h7_001100);
    tick();
    chk("t5_b", 32'({rd_valid_b, rd_data_b}), 32'h7_001100);
    read_word(5'd4, va, vb);
    chk("t5_a_word4", 32'(va), 32'h11);
    chk("t5_b_word4", 32'(vb), 32'h11);

    // test 6: port 1 enable toggled 1,0,1
    rd_address_i = {5'd0, 5'd3, 5'd0}; rd_en_i = 3'b010;
    tick();
    chk("t6_a_e1", 32'({rd_valid_a, rd_data_a[15:8]}), 32'h2_5A);
    rd_address_i = {5'd0, 5'd5, 5'd0}; rd_en_i = 3'b000;
    tick();
    chk("t6_a_e2", 32'({rd_valid_a, rd_data_a[15:8]}), 32'h0_5A);
    chk("t6_b_e2", 32'({rd_valid_b, rd_data_b[15:8]}), 32'h2_5A);
    rd_address_i = {5'd0, 5'd7, 5'd0}; rd_en_i = 3'b010;
    tick();
    rd_en_i = 3'b000;
    chk("t6_a_e3", 32'({rd_valid_a, rd_data_a[15:8]}), 32'h2_11);
    chk("t6_b_e3", 32'({rd_valid_b, rd_data_b[15:8]}), 32'h0_5A);
    tick();
    chk("t6_b_e4", 32'({rd_valid_b, rd_data_b[15:8]}), 32'h2_11);

    // test 4: prefill 0xA0+i, start a sweep, then reset after six words
    for (int i = 0; i < 16; i++) begin
      wr_en_i = 1'b1; wr_address_i = 5'(i); wr_data_i = 8'(8'hA0 + i);
      tick();
    end
    wr_en_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (6) tick();
    reset_i = 1'b1;
    #1;
    chk("t4_rst_busy_a", 32'(busy_a), 32'd0);
    chk("t4_rst_busy_b", 32'(busy_b), 32'd1);
    chk("t4_rst_data_a", 32'({rd_valid_a, rd_data_a}), 32'd0);
    chk("t4_rst_data_b", 32'({rd_valid_b, rd_data_b}), 32'd0);
    chk("t4_rst_done_a", 32'(done_a), 32'd0);
    tick(); tick();
    reset_i = 1'b0;
    watch(1'b0, ab, ad, bb, bd);
    chk("t4_busy_a", 32'(ab), 32'd0);
    chk("t4_busy_b", 32'(bb), 32'd16);
    chk("t4_done_b", 32'(bd), 32'd1);
    for (int i = 0; i < 16; i++) begin
      read_word(5'(i), va, vb);
      chk($sformatf("t4_a_w%0d", i), 32'(va), (i < 6) ? 32'h11 : 32'(8'hA0 + i));
      chk($sformatf("t4_b_w%0d", i), 32'(vb), 32'h11);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
